// File: rtl/dl_demux32_reg.sv
// Registered 1-to-32 demultiplexer bank: steers one write word into one of 32
// holding registers and presents all entries with valid flags and a valid count.
module dl_demux32_reg #(
    parameter int NUM_BITS    = 32,
    parameter int ZERO_ENTRY0 = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] in,
    input  logic [4:0]          sel,
    input  logic                we,
    input  logic                clr,
    output logic [NUM_BITS-1:0] out0,
    output logic [NUM_BITS-1:0] out1,
    output logic [NUM_BITS-1:0] out2,
    output logic [NUM_BITS-1:0] out3,
    output logic [NUM_BITS-1:0] out4,
    output logic [NUM_BITS-1:0] out5,
    output logic [NUM_BITS-1:0] out6,
    output logic [NUM_BITS-1:0] out7,
    output logic [NUM_BITS-1:0] out8,
    output logic [NUM_BITS-1:0] out9,
    output logic [NUM_BITS-1:0] out10,
    output logic [NUM_BITS-1:0] out11,
    output logic [NUM_BITS-1:0] out12,
    output logic [NUM_BITS-1:0] out13,
    output logic [NUM_BITS-1:0] out14,
    output logic [NUM_BITS-1:0] out15,
    output logic [NUM_BITS-1:0] out16,
    output logic [NUM_BITS-1:0] out17,
    output logic [NUM_BITS-1:0] out18,
    output logic [NUM_BITS-1:0] out19,
    output logic [NUM_BITS-1:0] out20,
    output logic [NUM_BITS-1:0] out21,
    output logic [NUM_BITS-1:0] out22,
    output logic [NUM_BITS-1:0] out23,
    output logic [NUM_BITS-1:0] out24,
    output logic [NUM_BITS-1:0] out25,
    output logic [NUM_BITS-1:0] out26,
    output logic [NUM_BITS-1:0] out27,
    output logic [NUM_BITS-1:0] out28,
    output logic [NUM_BITS-1:0] out29,
    output logic [NUM_BITS-1:0] out30,
    output logic [NUM_BITS-1:0] out31,
    output logic [31:0]         vld,
    output logic [5:0]          num_vld
);

    localparam bit ZE = (ZERO_ENTRY0 != 0);

    logic [NUM_BITS-1:0] mem [32];
    logic [31:0]         vld_q;
    logic [31:0]         vld_next;
    logic [31:0]         vld_rst;
    logic [5:0]          num_q;
    logic [5:0]          cnt_next;
    logic                wr_ok;

    // A hardwired entry 0 is permanently valid, so it survives reset and clear.
    assign vld_rst = {31'b0, ZE};
    assign wr_ok   = we && !(ZE && (sel == 5'd0));

    // Count is taken from the next-state flags so it can never lag vld.
    always_comb begin
        vld_next = clr ? vld_rst : vld_q;
        if (wr_ok) begin
            vld_next[sel] = 1'b1;
        end
        cnt_next = '0;
        for (int i = 0; i < 32; i++) begin
            cnt_next = cnt_next + {5'b0, vld_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= vld_rst;
            num_q <= {5'b0, ZE};
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else begin
            vld_q <= vld_next;
            num_q <= cnt_next;
            // Write wins over clear for the selected entry: clear first, then write.
            for (int i = 0; i < 32; i++) begin
                if (wr_ok && (sel == 5'(i))) begin
                    mem[i] <= in;
                end else if (clr) begin
                    mem[i] <= '0;
                end
            end
        end
    end

    assign vld     = vld_q;
    assign num_vld = num_q;

    assign out0  = mem[0];
    assign out1  = mem[1];
    assign out2  = mem[2];
    assign out3  = mem[3];
    assign out4  = mem[4];
    assign out5  = mem[5];
    assign out6  = mem[6];
    assign out7  = mem[7];
    assign out8  = mem[8];
    assign out9  = mem[9];
    assign out10 = mem[10];
    assign out11 = mem[11];
    assign out12 = mem[12];
    assign out13 = mem[13];
    assign out14 = mem[14];
    assign out15 = mem[15];
    assign out16 = mem[16];
    assign out17 = mem[17];
    assign out18 = mem[18];
    assign out19 = mem[19];
    assign out20 = mem[20];
    assign out21 = mem[21];
    assign out22 = mem[22];
    assign out23 = mem[23];
    assign out24 = mem[24];
    assign out25 = mem[25];
    assign out26 = mem[26];
    assign out27 = mem[27];
    assign out28 = mem[28];
    assign out29 = mem[29];
    assign out30 = mem[30];
    assign out31 = mem[31];

endmodule

// File: doc/dl_demux32_reg.md
Name: dl_demux32_reg

Overview:
- Registered 1-to-32 demultiplexer bank: the write/steer counterpart to the 32-to-1 read mux in the design library.
- Steers one NUM_BITS input word into one of 32 holding registers selected by a 5-bit index.
- All 32 registers are presented in parallel, with per-entry valid flags and a valid-entry count.
- Intended as the write side of register-file-like structures (GPR write-back, CSR shadow banks).

Parameters:
- NUM_BITS, 32, width of the data word and of each holding register.
- ZERO_ENTRY0, 0, when 1 entry 0 is hardwired: ignores writes, out0 is constant 0, vld[0] is constant 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  NUM_BITS  write data.
- sel  input  5  destination entry index 0..31.
- we  input  1  write enable; the write takes effect at the next rising edge.
- clr  input  1  synchronous bulk clear of all entries and valid flags.
- out0 .. out31  output  NUM_BITS each  registered contents of entries 0..31.
- vld  output  32  bit i = 1 when entry i was written since the last reset or clear.
- num_vld  output  6  registered population count of vld, range 0..32.

Behaviour:
- Reset:
  - On a rising edge with rst=1, every outN goes to 0, vld goes to 0 and num_vld goes to 0.
  - With ZERO_ENTRY0=1, vld[0] is 1 and num_vld resets to 1.
  - rst overrides we and clr. A write presented in the reset cycle is lost.
- Write:
  - we=1 at edge k updates entry sel with in; the new value is visible on out[sel] after edge k.
  - Latency is exactly 1 cycle.
  - vld[sel] is set at the same edge.
  - Entries other than sel are unchanged.
- Rewrite: writing an already-valid entry updates its data; vld and num_vld are unchanged.
- Hardwired entry: with ZERO_ENTRY0=1 and sel=0, the write is dropped. out0 stays 0, and vld/num_vld are unchanged.
- Clear:
  - clr=1 (we=0): all entries go to 0, vld goes to 0 (except bit 0 when ZERO_ENTRY0=1), and num_vld goes to 0 (1 when ZERO_ENTRY0=1).
- Clear and write in the same cycle:
  - The clear applies first, then the write.
  - After the edge, only entry sel holds in with vld[sel]=1; all other entries are 0.
  - num_vld = 1, or 2 if ZERO_ENTRY0=1 and sel!=0.
  - If ZERO_ENTRY0=1 and sel=0, the result equals a plain clear.
- num_vld:
  - Registered and updated at the same edge as vld, so it always equals popcount(vld) in the same cycle.
  - It must never lag vld.
  - Implemented incrementally (+1 on a write to an invalid entry, reload on clear) or by popcount of next-state vld. Either is acceptable if cycle-exact.
- Width: num_vld is 6 bits so that 32 is representable. It must not wrap or saturate below 32.
- sel coverage: all 5-bit values are legal; there is no out-of-range case and no X propagation from sel when we=0.
- X handling: with we=0 and clr=0, the state holds regardless of in and sel, even if they are X.
- Purely synchronous: outputs have no combinational path from in, sel, we or clr.

Test Plan:
- Reset and single write:
  - Stimulus: apply rst for 2 cycles, then we=1, sel=5, in=0xDEADBEEF for 1 cycle.
  - Response: all outN=0 and vld=0 during reset. After the edge, out5=0xDEADBEEF, vld=0x00000020, num_vld=1, all other outputs 0.
- Fill and rewrite:
  - Stimulus: write sel=i with in=i*0x01010101 for i=0..31 on consecutive cycles, then rewrite sel=31 with 0x12345678.
  - Response: num_vld increments 1..32 cycle by cycle and vld=0xFFFFFFFF at the end. After the rewrite, out31=0x12345678 and num_vld stays 32.
- Clear with simultaneous write:
  - Stimulus: from the full state, clr=1, we=1, sel=7, in=0xA5A5A5A5.
  - Response: out7=0xA5A5A5A5, every other outN=0, vld=0x00000080, num_vld=1.
- ZERO_ENTRY0=1:
  - Stimulus: reset, then write sel=0 with in=0xFFFFFFFF, then write sel=1 with in=0x1.
  - Response: out0=0 throughout. vld=0x1 and num_vld=1 after reset, unchanged after the sel=0 write. After the sel=1 write, vld=0x3 and num_vld=2.
- Reset mid-operation:
  - Stimulus: with 10 entries valid, assert rst together with we=1, sel=3.
  - Response: all entries are 0, vld=0 and num_vld=0 after the edge, and entry 3 is not written.
- Hold with X inputs:
  - Stimulus: we=0 and clr=0 with in and sel driven X for 5 cycles.
  - Response: all outputs are bit-identical to their values before the X window.
